alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 16, SHALL set the number of program words; it is fixed at 16 (4-bit pc).
REQ-002 Parameter MAX_STEPS, default 64, SHALL set the watchdog limit on instructions executed per run.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- prog_we  in  1  program write strobe
- prog_addr  in  4  program write address
- prog_data  in  8  instruction word {op[3:0], imm[3:0]}
- start  in  1  run request
- alu_carry  in  1  ALU Carry
- alu_zero  in  1  ALU Zero
- alu_out  in  4  ALU output bus
- alu_in  out  4  ALU operand
- alu_opcode  out  3  ALU opcode
- en_accu  out  1  accumulator enable
- en1  out  1  operand bus enable
- en2  out  1  result bus enable
- busy  out  1  run in progress
- done  out  1  one-cycle pulse on HALT
- err  out  1  sticky watchdog error
- result  out  4  alu_out captured at last FLAG
- pc  out  4  current program counter

Function
REQ-005 Decoding SHALL be: op 0000-0100 = ALU op (alu_opcode = op[2:0]); 1000 = HALT; 1001 = JZ imm; 1010 = JC imm; all other op values = NOP.
REQ-006 FSM states SHALL be IDLE, FETCH, EXEC, FLAG, BRANCH, DONE.
REQ-007 IDLE: on start=1, pc<=0, step count<=0, err<=0, flag regs z_q/c_q<=0, busy<=1, go to FETCH.
REQ-008 FETCH: read the word at pc; ALU op -> EXEC; JZ/JC/NOP -> BRANCH; HALT -> DONE.
REQ-009 EXEC (1 cycle): alu_in=imm, alu_opcode=op[2:0], en1=1, en_accu=1, en2=0.
REQ-010 FLAG (1 cycle): en1=1, en2=1, en_accu=0; capture result<=alu_out, z_q<=alu_zero, c_q<=alu_carry; pc<=pc+1; go to FETCH.
REQ-011 BRANCH (1 cycle): pc<=imm if (JZ and z_q) or (JC and c_q), else pc+1; go to FETCH.
REQ-012 DONE: done=1 for exactly one cycle, busy<=0, go to IDLE.
REQ-013 Latency SHALL be 3 cycles per ALU op, 2 per branch/NOP, 2 for HALT including the DONE cycle.
REQ-014 pc SHALL wrap 15->0 without error.
REQ-015 The step counter SHALL increment on every FETCH of a non-HALT word; on reaching MAX_STEPS the FSM SHALL go to IDLE with err=1, busy=0, and no done pulse.
REQ-016 start while busy SHALL be ignored; prog_we while busy SHALL be ignored; prog_we in IDLE SHALL write in one cycle.
REQ-017 In every state other than EXEC/FLAG, en_accu, en1, en2 SHALL be 0 and alu_in/alu_opcode SHALL be 0.

Reset
REQ-018 rst_n=0 SHALL asynchronously force: state IDLE, pc=0, busy=0, done=0, err=0, result=0, enables=0, alu_in=0, alu_opcode=0, z_q=c_q=0, every program word = 0x80 (HALT); this holds mid-run.

Configuration
REQ-019 With ALU_SEQ_BRANCH_EN defined, JZ/JC SHALL behave per REQ-011; without it, JZ/JC SHALL decode as NOP (pc+1, 2 cycles).

Structure
REQ-020 Package alu_seq_pkg SHALL hold the FSM state enum, instruction op constants (HALT, JZ, JC) and ALU opcode constants (PASS_A 000, CMP 001, PASS_B 010, ADD 011, NAND 100).
REQ-021 Program storage SHALL be a sub-module alu_seq_progmem (16x8 registers, async reset to 0x80, 1 write port, combinational read).

Verification (bench includes a behavioural accumulator ALU model)
REQ-022 Load {0x27,0x33,0x80}, start -> done in cycle 8 after start, result=0xA, zero=0, carry=0.
REQ-023 Load {0x2F,0x31,0x80}, start -> result=0x0, c_q=1, z_q=1, done pulse width 1.
REQ-024 Load {0x2F,0x31,0x94,0x80,0x25,0x80} -> with ALU_SEQ_BRANCH_EN result=0x5 at pc 5; without, result=0x0 at pc 3.
REQ-025 Load all 16 words 0x00 -> pc wraps, err=1 after 64 steps, busy=0, done never asserted.
REQ-026 Drop rst_n during EXEC of a run -> all outputs 0 immediately, program reads 0x80, a following start gives done after 2 cycles.
REQ-027 Pulse start and prog_we while busy -> run and program content unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer.
// Branch support is selected with ALU_SEQ_BRANCH_EN.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_FLAG,
    S_BRANCH,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] imm;
  } instr_t;

  localparam logic [3:0] OP_ALU_LAST = 4'b0100;
  localparam logic [3:0] OP_HALT     = 4'b1000;
  localparam logic [3:0] OP_JZ       = 4'b1001;
  localparam logic [3:0] OP_JC       = 4'b1010;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_CMP    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;

  localparam logic [7:0] WORD_HALT = {OP_HALT, 4'h0};

  function automatic logic is_alu_op(
    input logic [3:0] op
  );
    return op <= OP_ALU_LAST;
  endfunction

endpackage

// File: rtl/alu_seq_progmem.sv
// 16x8 program store for the ALU sequencer.
// Async reset fills every word with HALT; reads are combinational.
module alu_seq_progmem
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= WORD_HALT;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Microprogram sequencer driving an external accumulator ALU.
// Define ALU_SEQ_BRANCH_EN to enable JZ/JC; otherwise they act as NOP.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int MAX_STEPS  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       start,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic [3:0] alu_out,
  output logic [3:0] alu_in,
  output logic [2:0] alu_opcode,
  output logic       en_accu,
  output logic       en1,
  output logic       en2,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] result,
  output logic [3:0] pc
);

`ifdef ALU_SEQ_BRANCH_EN
  localparam bit BRANCH_EN = 1'b1;
`else
  localparam bit BRANCH_EN = 1'b0;
`endif

  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(MAX_STEPS);
  localparam logic [SW-1:0] STEP_ONE = SW'(1);

  state_t        r_state;
  logic [3:0]    r_pc;
  logic [SW-1:0] r_steps;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [3:0]    r_result;
  logic          r_zq;
  logic          r_cq;
  logic [3:0]    r_alu_in;
  logic [2:0]    r_alu_op;
  logic          r_en_accu;
  logic          r_en1;
  logic          r_en2;

  logic [7:0]    w_word;
  instr_t        w_instr;
  logic          w_we;
  logic          w_is_alu;
  logic          w_is_halt;
  logic          w_is_jz;
  logic          w_is_jc;
  logic          w_take;
  logic [SW-1:0] w_steps_nxt;

  assign w_we = prog_we & (r_state == S_IDLE);

  alu_seq_progmem #(
    .DEPTH (PROG_DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_word)
  );

  assign w_instr     = instr_t'(w_word);
  assign w_steps_nxt = r_steps + STEP_ONE;

  always_comb begin
    w_is_alu  = 1'b0;
    w_is_halt = 1'b0;
    w_is_jz   = 1'b0;
    w_is_jc   = 1'b0;
    unique case (1'b1)
      is_alu_op(w_instr.op):     w_is_alu  = 1'b1;
      (w_instr.op == OP_HALT):   w_is_halt = 1'b1;
      (w_instr.op == OP_JZ):     w_is_jz   = 1'b1;
      (w_instr.op == OP_JC):     w_is_jc   = 1'b1;
      default: ;
    endcase
  end

  // Without branch support JZ/JC fall through exactly like NOP.
  assign w_take = BRANCH_EN &
                  ((w_is_jz & r_zq) | (w_is_jc & r_cq));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= 4'h0;
      r_steps   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_result  <= 4'h0;
      r_zq      <= 1'b0;
      r_cq      <= 1'b0;
      r_alu_in  <= 4'h0;
      r_alu_op  <= ALU_PASS_A;
      r_en_accu <= 1'b0;
      r_en1     <= 1'b0;
      r_en2     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= 4'h0;
            r_steps <= '0;
            r_err   <= 1'b0;
            r_zq    <= 1'b0;
            r_cq    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_is_halt) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_steps_nxt == STEP_MAX) begin
            r_steps <= w_steps_nxt;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_steps <= w_steps_nxt;
            if (w_is_alu) begin
              r_alu_in  <= w_instr.imm;
              r_alu_op  <= w_instr.op[2:0];
              r_en1     <= 1'b1;
              r_en_accu <= 1'b1;
              r_state   <= S_EXEC;
            end else begin
              r_state <= S_BRANCH;
            end
          end
        end
        S_EXEC: begin
          r_alu_in  <= 4'h0;
          r_alu_op  <= ALU_PASS_A;
          r_en_accu <= 1'b0;
          r_en2     <= 1'b1;
          r_state   <= S_FLAG;
        end
        S_FLAG: begin
          r_result <= alu_out;
          r_zq     <= alu_zero;
          r_cq     <= alu_carry;
          r_pc     <= r_pc + 4'h1;
          r_en1    <= 1'b0;
          r_en2    <= 1'b0;
          r_state  <= S_FETCH;
        end
        S_BRANCH: begin
          r_pc    <= w_take ? w_instr.imm : r_pc + 4'h1;
          r_state <= S_FETCH;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_in     = r_alu_in;
  assign alu_opcode = r_alu_op;
  assign en_accu    = r_en_accu;
  assign en1        = r_en1;
  assign en2        = r_en2;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign result     = r_result;
  assign pc         = r_pc;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural accumulator ALU.
// Expected branch behaviour follows ALU_SEQ_BRANCH_EN.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'h0;
  logic [7:0] prog_data = 8'h00;
  logic       start = 1'b0;
  logic       alu_carry;
  logic       alu_zero;
  logic [3:0] alu_out;
  logic [3:0] alu_in;
  logic [2:0] alu_opcode;
  logic       en_accu;
  logic       en1;
  logic       en2;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] result;
  logic [3:0] pc;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .alu_out    (alu_out),
    .alu_in     (alu_in),
    .alu_opcode (alu_opcode),
    .en_accu    (en_accu),
    .en1        (en1),
    .en2        (en2),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .pc         (pc)
  );

  // Accumulator ALU: updates on en_accu, drives bus and flags on en2.
  logic [3:0] m_acc;
  logic       m_z;
  logic       m_c;
  logic [4:0] m_sum;

  assign m_sum     = {1'b0, m_acc} + {1'b0, alu_in};
  assign alu_out   = en2 ? m_acc : 4'h0;
  assign alu_zero  = en2 & m_z;
  assign alu_carry = en2 & m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= 4'h0;
      m_z   <= 1'b0;
      m_c   <= 1'b0;
    end else if (en_accu) begin
      case (alu_opcode)
        3'd0: begin
          m_z <= (m_acc == 4'h0);
          m_c <= 1'b0;
        end
        3'd1: begin
          m_z <= (m_acc == alu_in);
          m_c <= (m_acc < alu_in);
        end
        3'd2: begin
          m_acc <= alu_in;
          m_z   <= (alu_in == 4'h0);
          m_c   <= 1'b0;
        end
        3'd3: begin
          m_acc <= m_sum[3:0];
          m_z   <= (m_sum[3:0] == 4'h0);
          m_c   <= m_sum[4];
        end
        3'd4: begin
          m_acc <= ~(m_acc & alu_in);
          m_z   <= ((m_acc & alu_in) == 4'hF);
          m_c   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    string      name;
    logic [3:0] res;
    logic [3:0] pc;
    bit         chk_pc;
    logic       err;
    int         dones;
    int         done_at;
    logic       zq;
    logic       cq;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] prog [16];

  function automatic void chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: measures each run and checks it against the queue head.
  bit m_run = 1'b0;
  int m_cyc;
  int m_dones;
  int m_done_at;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_run = 1'b0;
    end else if (busy) begin
      if (!m_run) begin
        m_run     = 1'b1;
        m_cyc     = 0;
        m_dones   = 0;
        m_done_at = -1;
      end
      m_cyc++;
      if (done) begin
        m_dones++;
        if (m_done_at < 0) m_done_at = m_cyc;
      end
    end else if (m_run) begin
      exp_t e;
      m_run = 1'b0;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_run: got run end expected none");
      end else begin
        e = q.pop_front();
        chk({e.name, ".result"}, 32'(result), 32'(e.res));
        if (e.chk_pc) chk({e.name, ".pc"}, 32'(pc), 32'(e.pc));
        chk({e.name, ".err"}, 32'(err), 32'(e.err));
        chk({e.name, ".done_cnt"}, m_dones, e.dones);
        chk({e.name, ".done_at"}, m_done_at, e.done_at);
        chk({e.name, ".z_q"}, 32'(dut.r_zq), 32'(e.zq));
        chk({e.name, ".c_q"}, 32'(dut.r_cq), 32'(e.cq));
      end
    end
  end

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = prog[i];
    end
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic expect_run(
    input string      nm,
    input logic [3:0] res,
    input logic [3:0] epc,
    input bit         cpc,
    input logic       eerr,
    input int         nd,
    input int         dat,
    input logic       zq,
    input logic       cq
  );
    exp_t e;
    e.name = nm; e.res = res; e.pc = epc; e.chk_pc = cpc;
    e.err = eerr; e.dones = nd; e.done_at = dat;
    e.zq = zq; e.cq = cq;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.timeout: got busy=1 expected busy=0", nm);
    end
    @(negedge clk);
  endtask

  task automatic run(
    input string      nm,
    input logic [3:0] res,
    input logic [3:0] epc,
    input bit         cpc,
    input logic       eerr,
    input int         nd,
    input int         dat,
    input logic       zq,
    input logic       cq
  );
    expect_run(nm, res, epc, cpc, eerr, nd, dat, zq, cq);
    pulse_start();
    wait_idle(nm);
  endtask

  function automatic logic [31:0] outvec();
    return 32'({alu_in, alu_opcode, en_accu, en1, en2,
                busy, done, err, result, pc});
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.outputs", outvec(), 32'h0);
    chk("reset.flags", 32'({dut.r_zq, dut.r_cq}), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    prog[0] = 8'h27; prog[1] = 8'h33; prog[2] = 8'h80;
    load(3);
    run("add", 4'hA, 4'd2, 1, 0, 1, 8, 0, 0);

    prog[0] = 8'h2F; prog[1] = 8'h31; prog[2] = 8'h80;
    load(3);
    run("carry", 4'h0, 4'd2, 1, 0, 1, 8, 1, 1);

    prog[0] = 8'h2F; prog[1] = 8'h31; prog[2] = 8'h94;
    prog[3] = 8'h80; prog[4] = 8'h25; prog[5] = 8'h80;
    load(6);
`ifdef ALU_SEQ_BRANCH_EN
    run("jz", 4'h5, 4'd5, 1, 0, 1, 13, 0, 0);
`else
    run("jz_nop", 4'h0, 4'd3, 1, 0, 1, 10, 1, 1);
`endif

    prog[0] = 8'h27; prog[1] = 8'h33; prog[2] = 8'h80;
    load(3);
    expect_run("busy_ign", 4'hA, 4'd2, 1, 0, 1, 8, 0, 0);
    pulse_start();
    @(posedge clk); #1;
    start = 1'b1; prog_we = 1'b1;
    prog_addr = 4'd1; prog_data = 8'h80;
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    wait_idle("busy_ign");
    run("rerun", 4'hA, 4'd2, 1, 0, 1, 8, 0, 0);

    pulse_start();
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (en_accu) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        n_tests++;
        n_fail++;
        $display("FAIL exec_wait.timeout: got en_accu=0 expected 1");
      end
    end
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset.outputs", outvec(), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run("after_reset", 4'h0, 4'd0, 1, 0, 1, 2, 0, 0);

    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    load(16);
    run("watchdog", 4'h0, 4'd0, 0, 1, 0, -1, 1, 0);

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
